// File: rtl/ser_shift_pkg.sv
// Shared constants and FSM state type for the bit-serial shift sequencer.
package ser_shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } shift_seq_state_t;

endpackage

// File: rtl/ser_shift_seq.sv
// Sequencer feeding the bit-serial shifter: streams operand A in, captures the shift amount, frames the result.
// Optional abort input enabled by defining SER_SHIFT_SEQ_ABORT_EN.
module ser_shift_seq
  import ser_shift_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
`ifdef SER_SHIFT_SEQ_ABORT_EN
  input  logic               i_abort,
`endif
  input  logic               i_start,
  input  logic               i_right,
  input  logic               i_signed,
  input  logic               i_op_a,
  input  logic               i_op_b,
  output logic               o_ready,
  output logic               o_load,
  output logic [SHAMT_W-1:0] o_shamt,
  output logic               o_signed,
  output logic               o_right,
  output logic               o_d,
  input  logic               i_q,
  output logic               o_rd,
  output logic               o_rd_valid,
  output logic               o_done
);

  shift_seq_state_t   r_state;
  shift_seq_state_t   w_state_next;
  logic [SHAMT_W-1:0] r_cnt;
  logic [SHAMT_W-1:0] w_cnt_next;
  logic [SHAMT_W-1:0] r_shamt;
  logic [SHAMT_W-1:0] w_shamt_cap;
  logic               r_right;
  logic               r_signed;
  logic               w_accept;
  logic               w_abort;

`ifdef SER_SHIFT_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Only the first SHAMT_W operand-B bits land in the shift amount.
  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_shamt
      assign w_shamt_cap[gi] = (r_state == LOAD && r_cnt == SHAMT_W'(gi)) ? i_op_b : r_shamt[gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    o_ready      = 1'b0;
    o_load       = 1'b0;
    o_d          = 1'b0;
    o_rd         = 1'b0;
    o_rd_valid   = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start && !w_abort) begin
          w_accept     = 1'b1;
          w_state_next = LOAD;
          w_cnt_next   = '0;
        end
      end
      LOAD: begin
        o_load     = 1'b1;
        o_d        = i_op_a;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = OUT;
      end
      OUT: begin
        o_rd       = i_q;
        o_rd_valid = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          o_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
    // An abort ends the sequence silently; the latched direction flags survive.
    if (w_abort && r_state != IDLE) begin
      o_done       = 1'b0;
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shamt  <= '0;
      r_right  <= 1'b0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept || (w_abort && r_state != IDLE)) begin
        r_shamt <= '0;
      end else begin
        r_shamt <= w_shamt_cap;
      end
      if (w_accept) begin
        r_right  <= i_right;
        r_signed <= i_signed;
      end
    end
  end

  assign o_shamt  = r_shamt;
  assign o_right  = r_right;
  assign o_signed = r_signed;

endmodule

// File: doc/ser_shift_seq.md
Name: ser_shift_seq

Overview:
- Sequencer sitting directly upstream of the bit-serial shifter `ser_shift`.
- Accepts a shift request from the serial core datapath and streams operand A (LSB first) into the shifter's load port.
- Captures the 5-bit shift amount serially from operand B and drives the shifter's `i_load`/`i_shamt`/`i_signed`/`i_right`.
- Forwards the shifter's serial result to the rd writeback path with valid/done framing.

Parameters:
- XLEN, 32, operand width; only 32 is supported (shifter is fixed 32-bit).
- SHAMT_W, 5, shift-amount width; must equal log2(XLEN).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  request; sampled only while o_ready=1.
- i_right  in  1  1=right shift, 0=left; latched on accepted start.
- i_signed  in  1  arithmetic right shift; latched on accepted start.
- i_op_a  in  1  serial operand A bit, LSB first, cycles 1..32 after start.
- i_op_b  in  1  serial operand B bit, same timing; only bits 0..4 used.
- o_ready  out  1  high in IDLE only.
- o_load  out  1  to shifter `i_load`.
- o_shamt  out  5  to shifter `i_shamt`.
- o_signed  out  1  to shifter `i_signed`.
- o_right  out  1  to shifter `i_right`.
- o_d  out  1  to shifter `i_d`.
- i_q  in  1  from shifter `o_q`.
- o_rd  out  1  serial result bit, LSB first.
- o_rd_valid  out  1  qualifies o_rd.
- o_done  out  1  single-cycle pulse on the last result bit.

Behaviour:
- Reset: state=IDLE, cnt=0, shamt=0, latched right/signed=0.
  - Output values under reset: o_ready=1; o_load, o_rd_valid, o_done, o_rd=0; o_shamt=0, o_signed=0, o_right=0.
  - Reset wins over every other event.
- FSM states: IDLE, LOAD, OUT.
  - IDLE -> LOAD when i_start=1 (cycle 0); latch i_right and i_signed; clear cnt and shamt.
  - LOAD, cycles 1..32:
    - o_load=1; o_d = i_op_a combinationally.
    - cnt increments each cycle.
    - When cnt<5, shamt[cnt] <= i_op_b.
    - At cnt==31: cnt wraps to 0, state -> OUT.
  - OUT, cycles 33..64:
    - o_load=0; o_rd=i_q; o_rd_valid=1; cnt increments.
    - At cnt==31: o_done=1, state -> IDLE.
- o_shamt is driven from the shamt register and held constant through OUT. The shifter relies on its value during output.
  - Partial shamt values during LOAD cycles 1..5 are harmless: the shifter reloads its count on every load cycle, and the final load cycle (32) sees the complete value.
- Latency: start to first result bit = 33 cycles; total 64 cycles; next start accepted no earlier than cycle 65.
- i_start while not IDLE: ignored, no queuing.
- i_op_b bits 5..31 never affect shamt, so op_b=0xFFFF_FFE3 gives shamt=3.
- o_right and o_signed are the latched copies, stable from cycle 1 until the next accepted start.
- No backpressure: the consumer must accept one rd bit per cycle while o_rd_valid=1.
- Reset asserted mid-LOAD or mid-OUT: next cycle IDLE, o_load=0, o_rd_valid=0, no o_done pulse. Shifter state is don't-care, because the next LOAD fully overwrites it.

Optional Feature:
- Macro: SER_SHIFT_SEQ_ABORT_EN.
- Defined: adds input i_abort (1 bit).
  - i_abort=1 in LOAD or OUT -> IDLE next cycle, same as reset except for the latched flags.
  - No o_done pulse is generated.
  - i_abort in IDLE has no effect; i_abort has priority over i_start.
- Undefined: the port does not exist and a sequence always runs its full 64 cycles.

Decomposition:
- Package `ser_shift_pkg`:
  - constants XLEN=32 and SHAMT_W=5;
  - state enum `shift_seq_state_t` {IDLE, LOAD, OUT};
  - constant CNT_LAST=31.
- No sub-module: the 5-bit counter and FSM are inline.
- `ser_shift` is instantiated beside this block in the ALU, not inside it. The bench instantiates both.

Test Plan:
- SLL: op_a=0x0000_0001, op_b=4, right=0 -> rd=0x0000_0010; o_done at cycle 64; o_ready high again at 65.
- SRA: op_a=0x8000_0000, op_b=4, right=1, signed=1 -> rd=0xF800_0000. Same with signed=0 -> 0x0800_0000.
- Zero shift / shamt masking: op_a=0xDEAD_BEEF, op_b=0 -> rd=0xDEAD_BEEF. op_b=0xFFFF_FFE3 with SRL on 0x0000_0080 -> 0x0000_0010.
- Busy and back-to-back:
  - i_start held high for 70 cycles -> exactly one sequence in cycles 0..64.
  - Second start accepted at cycle 65; o_load never asserts during OUT.
- Reset at cycle 40 (mid-OUT):
  - cycle 41: o_rd_valid=0, o_ready=1, no o_done;
  - a following SLL 0x3 by 1 -> 0x6.
- With SER_SHIFT_SEQ_ABORT_EN: i_abort at cycle 10 -> IDLE at cycle 11, no o_rd_valid. Abort and start in the same IDLE cycle -> start ignored.
